// File: rtl/jtopl_eg_sched_if.sv
// Register-side write port of the envelope slot scheduler.
// The requester holds wr_req until the scheduler answers with a one-clock wr_ack.
interface jtopl_eg_sched_if;
  logic       wr_req;
  logic [1:0] wr_sel;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_ack;

  modport master (
    output wr_req,
    output wr_sel,
    output wr_addr,
    output wr_data,
    input  wr_ack
  );

  modport slave (
    input  wr_req,
    input  wr_sel,
    input  wr_addr,
    input  wr_data,
    output wr_ack
  );
endinterface

// File: rtl/jtopl_eg_sched.sv
// Envelope-attenuation slot scheduler: stores per-operator and per-channel parameters and
// presents one registered, coherent parameter set per slot on every clock-enable.
module jtopl_eg_sched #(
  parameter int SLOTS = 18,
  parameter int CHANS = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cen,
  jtopl_eg_sched_if.slave   wr,
  output logic [4:0]        slot,
  output logic              zero,
  output logic              valid,
  output logic [5:0]        tl,
  output logic [1:0]        ksl,
  output logic              amsen,
  output logic [3:0]        fnum,
  output logic [2:0]        block
);

  localparam int SW = 5;
  localparam int CW = $clog2(CHANS);
  localparam logic [4:0] SLOTS_W = 5'(SLOTS);
  localparam logic [4:0] CHANS_W = 5'(CHANS);
  localparam logic [4:0] LAST_W  = 5'(SLOTS - 1);

  localparam logic [1:0] SEL_KT  = 2'd0;
  localparam logic [1:0] SEL_AM  = 2'd1;
  localparam logic [1:0] SEL_CH  = 2'd2;

  logic [SW-1:0] cnt_r;
  logic          wr_ack_r;

  logic [5:0] tl_mem_r    [SLOTS];
  logic [1:0] ksl_mem_r   [SLOTS];
  logic       am_mem_r    [SLOTS];
  logic [3:0] fnum_mem_r  [CHANS];
  logic [2:0] block_mem_r [CHANS];

  logic          accept_s;
  logic          we_kt_s;
  logic          we_am_s;
  logic          we_ch_s;
  logic [SW-1:0] op_idx_s;
  logic [CW-1:0] ch_wr_idx_s;
  logic [CW-1:0] ch_rd_idx_s;

  // Slots in the upper half share the channel of slot s-CHANS.
  function automatic logic [CW-1:0] chan_of(input logic [SW-1:0] s);
    logic [SW-1:0] c;
    if (s < CHANS_W) begin
      c = s;
    end else begin
      c = s - CHANS_W;
    end
    return CW'(c);
  endfunction

  assign wr.wr_ack = wr_ack_r;

  // Write acceptance and field decode; out-of-range targets are acked without a store.
  always_comb begin
    accept_s    = wr.wr_req & ~wr_ack_r;
    we_kt_s     = 1'b0;
    we_am_s     = 1'b0;
    we_ch_s     = 1'b0;
    op_idx_s    = SW'(wr.wr_addr);
    ch_wr_idx_s = CW'(wr.wr_addr);
    if (accept_s) begin
      case (wr.wr_sel)
        SEL_KT:  we_kt_s = (wr.wr_addr < SLOTS_W);
        SEL_AM:  we_am_s = (wr.wr_addr < SLOTS_W);
        SEL_CH:  we_ch_s = (wr.wr_addr < CHANS_W);
        default: begin
          we_kt_s = 1'b0;
          we_am_s = 1'b0;
          we_ch_s = 1'b0;
        end
      endcase
    end else begin
      we_kt_s = 1'b0;
      we_am_s = 1'b0;
      we_ch_s = 1'b0;
    end
  end

  // Read side channel index for the slot being loaded.
  always_comb begin
    ch_rd_idx_s = chan_of(cnt_r);
  end

  // Write acknowledge: one clock high after each accepted write, blocks back-to-back accepts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ack_r <= 1'b0;
    end else begin
      wr_ack_r <= accept_s;
    end
  end

  // Per-operator parameter storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SLOTS; i++) begin
        tl_mem_r[i]  <= 6'd0;
        ksl_mem_r[i] <= 2'd0;
        am_mem_r[i]  <= 1'b0;
      end
    end else begin
      if (we_kt_s) begin
        tl_mem_r[op_idx_s]  <= wr.wr_data[5:0];
        ksl_mem_r[op_idx_s] <= wr.wr_data[7:6];
      end
      if (we_am_s) begin
        am_mem_r[op_idx_s] <= wr.wr_data[0];
      end
    end
  end

  // Per-channel parameter storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANS; i++) begin
        fnum_mem_r[i]  <= 4'd0;
        block_mem_r[i] <= 3'd0;
      end
    end else if (we_ch_s) begin
      fnum_mem_r[ch_wr_idx_s]  <= wr.wr_data[3:0];
      block_mem_r[ch_wr_idx_s] <= wr.wr_data[6:4];
    end
  end

  // Slot scan: storage reads here see pre-write values, so a colliding write shows next pass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= 5'd0;
      slot  <= 5'd0;
      zero  <= 1'b0;
      valid <= 1'b0;
      tl    <= 6'd0;
      ksl   <= 2'd0;
      amsen <= 1'b0;
      fnum  <= 4'd0;
      block <= 3'd0;
    end else if (cen) begin
      slot  <= cnt_r;
      zero  <= (cnt_r == 5'd0);
      valid <= 1'b1;
      tl    <= tl_mem_r[cnt_r];
      ksl   <= ksl_mem_r[cnt_r];
      amsen <= am_mem_r[cnt_r];
      fnum  <= fnum_mem_r[ch_rd_idx_s];
      block <= block_mem_r[ch_rd_idx_s];
      cnt_r <= (cnt_r == LAST_W) ? 5'd0 : cnt_r + 5'd1;
    end
  end

endmodule

// File: tb/tb_jtopl_eg_sched.sv
// Scoreboard bench for jtopl_eg_sched: the driver queues the expected slot set per cen pulse,
// a monitor pops and compares each loaded set and checks the write-acknowledge timing.
module tb_jtopl_eg_sched;

  typedef struct packed {
    logic [4:0] slot;
    logic       zero;
    logic [5:0] tl;
    logic [1:0] ksl;
    logic       amsen;
    logic [3:0] fnum;
    logic [2:0] block;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cen = 1'b0;
  logic [4:0] slot;
  logic       zero, valid, amsen;
  logic [5:0] tl;
  logic [1:0] ksl;
  logic [3:0] fnum;
  logic [2:0] block;

  jtopl_eg_sched_if bus ();

  jtopl_eg_sched #(.SLOTS(18), .CHANS(9)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .wr(bus),
    .slot(slot), .zero(zero), .valid(valid), .tl(tl), .ksl(ksl),
    .amsen(amsen), .fnum(fnum), .block(block)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];
  int   m_cnt = 0;
  logic exp_ack = 1'b0;

  // reference parameter store, updated on modelled write acceptance
  logic [5:0] m_tl  [18];
  logic [1:0] m_ksl [18];
  logic       m_am  [18];
  logic [3:0] m_fn  [9];
  logic [2:0] m_blk [9];

  // last observed set per slot
  logic [5:0] obs_tl  [18];
  logic [1:0] obs_ksl [18];
  logic       obs_am  [18];
  logic [3:0] obs_fn  [18];
  logic [2:0] obs_blk [18];

  task automatic chk(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 18; i++) begin
      m_tl[i] = 6'd0; m_ksl[i] = 2'd0; m_am[i] = 1'b0;
    end
    for (int i = 0; i < 9; i++) begin
      m_fn[i] = 4'd0; m_blk[i] = 3'd0;
    end
  endtask

  task automatic push_exp();
    exp_t e;
    int   c;
    c       = (m_cnt < 9) ? m_cnt : m_cnt - 9;
    e.slot  = 5'(m_cnt);
    e.zero  = (m_cnt == 0);
    e.tl    = m_tl[m_cnt];
    e.ksl   = m_ksl[m_cnt];
    e.amsen = m_am[m_cnt];
    e.fnum  = m_fn[c];
    e.block = m_blk[c];
    exp_q.push_back(e);
    m_cnt = (m_cnt == 17) ? 0 : m_cnt + 1;
  endtask

  task automatic scan(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      push_exp();
      cen = 1'b1;
      @(negedge clk);
      cen = 1'b0;
    end
  endtask

  task automatic write(input logic [1:0] sel, input logic [4:0] addr, input logic [7:0] data);
    bit acked;
    acked = 1'b0;
    @(negedge clk);
    bus.wr_req = 1'b1; bus.wr_sel = sel; bus.wr_addr = addr; bus.wr_data = data;
    for (int i = 0; i < 8 && !acked; i++) begin
      @(posedge clk);
      #1;
      acked = wr_ack_now();
    end
    chk("write_acked", int'(acked), 1);
    @(negedge clk);
    bus.wr_req = 1'b0;
    @(posedge clk);
    #1;
    chk("ack_one_clk", int'(bus.wr_ack), 0);
  endtask

  function automatic bit wr_ack_now();
    return bus.wr_ack;
  endfunction

  // Monitor: models write acceptance, checks wr_ack every clock and pops one set per cen edge.
  initial begin
    exp_t e, got;
    logic s_cen, s_acc;
    model_clear();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_clear();
        exp_ack = 1'b0;
        exp_q.delete();
        continue;
      end
      s_cen = cen;
      s_acc = bus.wr_req && !exp_ack;
      if (s_acc) begin
        case (bus.wr_sel)
          2'd0: if (bus.wr_addr < 5'd18) begin
                  m_tl[bus.wr_addr]  = bus.wr_data[5:0];
                  m_ksl[bus.wr_addr] = bus.wr_data[7:6];
                end
          2'd1: if (bus.wr_addr < 5'd18) m_am[bus.wr_addr] = bus.wr_data[0];
          2'd2: if (bus.wr_addr < 5'd9) begin
                  m_fn[bus.wr_addr]  = bus.wr_data[3:0];
                  m_blk[bus.wr_addr] = bus.wr_data[6:4];
                end
          default: ;
        endcase
      end
      #1;
      chk("wr_ack", int'(bus.wr_ack), int'(s_acc));
      exp_ack = s_acc;
      if (s_cen) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_load", 1, 0);
        end else begin
          e   = exp_q.pop_front();
          got = '{slot, zero, tl, ksl, amsen, fnum, block};
          chk("slot_set", int'(got), int'(e));
          chk("valid", int'(valid), 1);
          if (slot < 5'd18) begin
            obs_tl[slot] = tl; obs_ksl[slot] = ksl; obs_am[slot] = amsen;
            obs_fn[slot] = fnum; obs_blk[slot] = block;
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] pat;
    bus.wr_req = 1'b0; bus.wr_sel = 2'd0; bus.wr_addr = 5'd0; bus.wr_data = 8'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_outputs", int'({slot, zero, valid, tl, ksl, amsen, fnum, block, bus.wr_ack}), 0);

    // full pass plus two slots, cen every second clock
    scan(20);
    chk("pass_end_slot", int'(slot), 1);
    chk("pass_end_zero", int'(zero), 0);

    write(2'd0, 5'd5, 8'hC7);
    scan(18);
    chk("s5_tl", int'(obs_tl[5]), 7);
    chk("s5_ksl", int'(obs_ksl[5]), 3);
    chk("s4_tl", int'(obs_tl[4]), 0);
    chk("s6_ksl", int'(obs_ksl[6]), 0);

    write(2'd2, 5'd3, 8'h5A);
    scan(18);
    chk("s3_fnum", int'(obs_fn[3]), 'hA);
    chk("s3_block", int'(obs_blk[3]), 5);
    chk("s12_fnum", int'(obs_fn[12]), 'hA);
    chk("s12_block", int'(obs_blk[12]), 5);
    chk("s4_fnum", int'(obs_fn[4]), 0);
    chk("s13_block", int'(obs_blk[13]), 0);

    // request held six clocks: acks on alternate clocks only
    @(negedge clk);
    bus.wr_req = 1'b1; bus.wr_sel = 2'd1; bus.wr_addr = 5'd2; bus.wr_data = 8'h01;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      pat[i] = bus.wr_ack;
    end
    @(negedge clk);
    bus.wr_req = 1'b0;
    chk("held_req_acks", int'(pat), 'b010101);

    write(2'd0, 5'd20, 8'hFF);
    write(2'd3, 5'd0, 8'hFF);
    write(2'd3, 5'd9, 8'h3F);
    write(2'd2, 5'd9, 8'hFF);
    write(2'd1, 5'd18, 8'h01);
    scan(18);
    chk("oor_s0_tl", int'(obs_tl[0]), 0);
    chk("oor_s9_fnum", int'(obs_fn[9]), 0);
    chk("s2_amsen", int'(obs_am[2]), 1);
    chk("oor_s5_tl", int'(obs_tl[5]), 7);

    // collision: write slot 9 on the edge that loads slot 9
    while (m_cnt != 9) scan(1);
    @(negedge clk);
    bus.wr_req = 1'b1; bus.wr_sel = 2'd0; bus.wr_addr = 5'd9; bus.wr_data = 8'h01;
    push_exp();
    cen = 1'b1;
    @(negedge clk);
    cen = 1'b0;
    bus.wr_req = 1'b0;
    chk("coll_old_tl", int'(obs_tl[9]), 0);
    chk("coll_slot", int'(slot), 9);
    scan(18);
    chk("coll_new_tl", int'(obs_tl[9]), 1);

    // reset mid-pass at slot 11 with an acknowledge pending
    while (m_cnt != 12) scan(1);
    @(negedge clk);
    bus.wr_req = 1'b1; bus.wr_sel = 2'd0; bus.wr_addr = 5'd7; bus.wr_data = 8'h3F;
    @(posedge clk);
    #1;
    chk("rst_ack_pending", int'(bus.wr_ack), 1);
    @(negedge clk);
    chk("rst_pre_slot", int'(slot), 11);
    rst_n = 1'b0;
    bus.wr_req = 1'b0;
    m_cnt = 0;
    #1;
    chk("midrst_outputs", int'({slot, zero, valid, tl, ksl, amsen, fnum, block, bus.wr_ack}), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    scan(18);
    chk("post_rst_s7_tl", int'(obs_tl[7]), 0);
    chk("post_rst_s5_tl", int'(obs_tl[5]), 0);
    chk("post_rst_s2_am", int'(obs_am[2]), 0);
    chk("post_rst_s12_fn", int'(obs_fn[12]), 0);
    chk("post_rst_s9_tl", int'(obs_tl[9]), 0);

    repeat (2) @(negedge clk);
    chk("sb_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
